// File: rtl/input_port_controller.sv
// rtl/input_port_controller.sv - NoC router input channel: 4-phase link RX, flit FIFO, XY route, switch TX.
// Optional IPC_ERR_CNT_EN adds err_cnt, a saturating count of orphan flits dropped in IDLE.
module input_port_controller #(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic [17:0] data_in,
  output logic        ack_in,
  output logic        req_port,
  output logic [2:0]  rout_port,
  input  logic [4:0]  grant_vec,
  output logic        req_out,
  output logic [17:0] data_out,
  input  logic [4:0]  ack_out_vec
`ifdef IPC_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  MY_X = 2'(ROUTER_X);
  localparam logic [1:0]  MY_Y = 2'(ROUTER_Y);
  localparam logic [2:0]  P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2, P_EAST = 3'd3, P_WEST = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GRANT, S_SEND, S_WAIT_ACK, S_WAIT_ACK_LOW, S_HOLD, S_RELEASE
  } state_t;

  state_t        r_state;
  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ack_in, r_req_port, r_req_out, r_last_tail;
  logic [2:0]    r_rout_port;
  logic [17:0]   r_data_out;

  logic [17:0]   w_front;
  logic          w_full, w_empty, w_push, w_pop, w_orphan;
  logic          w_grant_sel, w_ack_sel;
  logic [7:0]    w_grant8, w_ack8;
  logic [2:0]    w_route;

  assign w_front  = r_mem[r_rd_ptr];
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = req_in && !r_ack_in && !w_full;
  // Bit 16 set marks HEAD (01) and single (11); anything else at the front in IDLE is an orphan.
  assign w_orphan = (r_state == S_IDLE) && !w_empty && !w_front[16];
  assign w_grant8 = {3'b000, grant_vec};
  assign w_ack8   = {3'b000, ack_out_vec};
  assign w_grant_sel = w_grant8[r_rout_port];
  assign w_ack_sel   = w_ack8[r_rout_port];
  assign w_pop    = w_orphan || ((r_state == S_WAIT_ACK) && w_ack_sel);

  always_comb begin
    w_route = P_LOCAL;
    if (w_front[3:2] > MY_X)      w_route = P_EAST;
    else if (w_front[3:2] < MY_X) w_route = P_WEST;
    else if (w_front[1:0] > MY_Y) w_route = P_SOUTH;
    else if (w_front[1:0] < MY_Y) w_route = P_NORTH;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack_in <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_push)                    r_ack_in <= 1'b1;
      else if (r_ack_in && !req_in)  r_ack_in <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_port  <= 1'b0;
      r_rout_port <= P_LOCAL;
      r_req_out   <= 1'b0;
      r_data_out  <= '0;
      r_last_tail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && w_front[16]) begin
            r_rout_port <= w_route;
            r_req_port  <= 1'b1;
            r_state     <= S_WAIT_GRANT;
          end
        end
        S_WAIT_GRANT: if (w_grant_sel) r_state <= S_SEND;
        S_SEND: begin
          r_req_out  <= 1'b1;
          r_data_out <= w_front;
          r_state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (w_ack_sel) begin
            r_req_out   <= 1'b0;
            r_last_tail <= w_front[17];
            r_state     <= S_WAIT_ACK_LOW;
          end
        end
        S_WAIT_ACK_LOW: begin
          if (!w_ack_sel) begin
            if (r_last_tail) begin
              r_req_port <= 1'b0;
              r_state    <= S_RELEASE;
            end else if (!w_empty) r_state <= S_SEND;
            else                   r_state <= S_HOLD;
          end
        end
        S_HOLD:    if (!w_empty) r_state <= S_SEND;
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IPC_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err_cnt <= '0;
    else if (w_orphan && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`endif

  assign ack_in    = r_ack_in;
  assign req_port  = r_req_port;
  assign rout_port = r_rout_port;
  assign req_out   = r_req_out;
  assign data_out  = r_data_out;
endmodule

// File: tb/tb_input_port_controller.sv
// tb/tb_input_port_controller.sv - scoreboard bench for input_port_controller at router (1,1), DEPTH 4.
module tb_input_port_controller;
  localparam logic [2:0] P_L = 3'd0, P_N = 3'd1, P_S = 3'd2, P_E = 3'd3, P_W = 3'd4;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic        clk, rst, req_in, ack_in, req_port, req_out;
  logic [17:0] data_in, data_out;
  logic [2:0]  rout_port;
  logic [4:0]  grant_vec, ack_out_vec;
  logic        grant_en, ack_en, sw_ack;
`ifdef IPC_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  input_port_controller #(.ROUTER_X(1), .ROUTER_Y(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_in(ack_in),
    .req_port(req_port), .rout_port(rout_port), .grant_vec(grant_vec),
    .req_out(req_out), .data_out(data_out), .ack_out_vec(ack_out_vec)
`ifdef IPC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-switch model: grant and ack only on the selected channel
  assign grant_vec   = grant_en ? (5'd1 << rout_port) : 5'd0;
  assign ack_out_vec = sw_ack   ? (5'd1 << rout_port) : 5'd0;

  int n_chk = 0, n_pass = 0, n_acc = 0;
  logic [20:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [17:0] mk(input logic [1:0] t, input logic [11:0] tag,
                                     input logic [1:0] dx, input logic [1:0] dy);
    return {t, tag, dx, dy};
  endfunction

  task automatic expect_flit(input logic [2:0] port, input logic [17:0] f);
    sb_q.push_back({port, f});
  endtask

  initial begin
    sw_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (req_out && ack_en) sw_ack = 1'b1;
      else if (!req_out)     sw_ack = 1'b0;
    end
  end

  initial begin
    logic        prev;
    logic [20:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req_out && !prev) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got flit %0h expected none", data_out);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", 32'(data_out), 32'(e[17:0]));
          chk("sb_port", 32'(rout_port), 32'(e[20:18]));
          chk("sb_req_port", 32'(req_port), 32'd1);
        end
      end
      prev = req_out;
    end
  end

  task automatic send_flit(input logic [17:0] f);
    int k;
    data_in = f;
    req_in  = 1'b1;
    k = 0;
    while (!ack_in && k < 300) begin @(negedge clk); k++; end
    chk("link_ack_rise", 32'(ack_in), 32'd1);
    req_in = 1'b0;
    k = 0;
    while (ack_in && k < 20) begin @(negedge clk); k++; end
    chk("link_ack_fall", 32'(ack_in), 32'd0);
    n_acc++;
  endtask

  task automatic wait_req_port(input logic v, input string nm);
    int k = 0;
    while (req_port !== v && k < 200) begin @(negedge clk); k++; end
    chk(nm, 32'(req_port), 32'(v));
  endtask

  task automatic wait_req_out(input logic v, input string nm);
    int k = 0;
    while (req_out !== v && k < 200) begin @(negedge clk); k++; end
    chk(nm, 32'(req_out), 32'(v));
  endtask

  logic [17:0] t4 [6];
  logic [17:0] fa, fb, fc;

  initial begin
    rst = 1'b0; req_in = 1'b0; data_in = '0; grant_en = 1'b0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack_in", 32'(ack_in), 32'd0);
    chk("rst_req_port", 32'(req_port), 32'd0);
    chk("rst_rout_port", 32'(rout_port), 32'd0);
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
`ifdef IPC_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // 1: single flit to (3,1) goes EAST
    fa = mk(T_SINGLE, 12'hA51, 2'd3, 2'd1);
    expect_flit(P_E, fa);
    send_flit(fa);
    wait_req_port(1'b1, "t1_req_port_rise");
    chk("t1_rout_east", 32'(rout_port), 32'(P_E));
    grant_en = 1'b1;
    wait_req_port(1'b0, "t1_req_port_fall");

    // 2: four-flit packet to (1,0) goes NORTH, with an upstream stall mid-packet
    grant_en = 1'b0;
    expect_flit(P_N, mk(T_HEAD, 12'h201, 2'd1, 2'd0));
    expect_flit(P_N, mk(T_BODY, 12'h202, 2'd0, 2'd0));
    expect_flit(P_N, mk(T_BODY, 12'h203, 2'd3, 2'd3));
    expect_flit(P_N, mk(T_TAIL, 12'h204, 2'd2, 2'd2));
    send_flit(mk(T_HEAD, 12'h201, 2'd1, 2'd0));
    wait_req_port(1'b1, "t2_req_port_rise");
    chk("t2_rout_north", 32'(rout_port), 32'(P_N));
    grant_en = 1'b1;
    send_flit(mk(T_BODY, 12'h202, 2'd0, 2'd0));
    repeat (10) @(negedge clk);
    chk("t2_hold_req_port", 32'(req_port), 32'd1);
    chk("t2_hold_req_out", 32'(req_out), 32'd0);
    send_flit(mk(T_BODY, 12'h203, 2'd3, 2'd3));
    send_flit(mk(T_TAIL, 12'h204, 2'd2, 2'd2));
    wait_req_port(1'b0, "t2_req_port_fall");
    chk("t2_sb_drained", 32'(sb_q.size()), 32'd0);

    // 3: LOCAL destination, grant withheld 10 cycles
    grant_en = 1'b0;
    expect_flit(P_L, mk(T_SINGLE, 12'h301, 2'd1, 2'd1));
    send_flit(mk(T_SINGLE, 12'h301, 2'd1, 2'd1));
    repeat (10) @(negedge clk);
    chk("t3_req_port_held", 32'(req_port), 32'd1);
    chk("t3_req_out_low", 32'(req_out), 32'd0);
    chk("t3_rout_local", 32'(rout_port), 32'd0);
    grant_en = 1'b1;
    wait_req_port(1'b0, "t3_req_port_fall");

    // 4: six flits into a 4-deep FIFO while grant is withheld; head to (0,1) goes WEST
    grant_en = 1'b0;
    t4[0] = mk(T_HEAD, 12'h401, 2'd0, 2'd1);
    for (int i = 1; i < 5; i++) t4[i] = mk(T_BODY, 12'(12'h400 + i + 1), 2'(i), 2'(i + 1));
    t4[5] = mk(T_TAIL, 12'h406, 2'd3, 2'd0);
    for (int i = 0; i < 6; i++) expect_flit(P_W, t4[i]);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_flit(t4[i]);
      end
      begin
        int k = 0;
        while (n_acc < 4 && k < 200) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        chk("t4_accepted_when_full", 32'(n_acc), 32'd4);
        chk("t4_ack_stalled", 32'(ack_in), 32'd0);
        chk("t4_rout_west", 32'(rout_port), 32'(P_W));
        grant_en = 1'b1;
      end
    join
    wait_req_port(1'b0, "t4_req_port_fall");
    chk("t4_sb_drained", 32'(sb_q.size()), 32'd0);

    // 5: two orphan bodies discarded, then HEAD to (1,2) goes SOUTH
    send_flit(mk(T_BODY, 12'h501, 2'd3, 2'd3));
    send_flit(mk(T_BODY, 12'h502, 2'd0, 2'd0));
    expect_flit(P_S, mk(T_HEAD, 12'h503, 2'd1, 2'd2));
    expect_flit(P_S, mk(T_TAIL, 12'h504, 2'd0, 2'd0));
    send_flit(mk(T_HEAD, 12'h503, 2'd1, 2'd2));
    send_flit(mk(T_TAIL, 12'h504, 2'd0, 2'd0));
    wait_req_port(1'b0, "t5_req_port_fall");
    chk("t5_sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef IPC_ERR_CNT_EN
    chk("t5_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // 6: reset while stuck in WAIT_ACK with another flit buffered and one mid-handshake
    ack_en = 1'b0;
    fa = mk(T_SINGLE, 12'h601, 2'd2, 2'd2);
    fb = mk(T_SINGLE, 12'h602, 2'd0, 2'd0);
    expect_flit(P_E, fa);
    send_flit(fa);
    wait_req_out(1'b1, "t6_req_out_rise");
    data_in = fb;
    req_in  = 1'b1;
    begin
      int k = 0;
      while (!ack_in && k < 20) begin @(negedge clk); k++; end
    end
    chk("t6_b_acked", 32'(ack_in), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_req_out_drop", 32'(req_out), 32'd0);
    chk("t6_req_port_drop", 32'(req_port), 32'd0);
    chk("t6_ack_in_drop", 32'(ack_in), 32'd0);
    chk("t6_data_out_clr", 32'(data_out), 32'd0);
    @(negedge clk);
    req_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_fifo_flushed", 32'(req_port), 32'd0);
    fc = mk(T_SINGLE, 12'h603, 2'd1, 2'd0);
    expect_flit(P_N, fc);
    send_flit(fc);
    wait_req_port(1'b1, "t6_after_rst_rise");
    wait_req_port(1'b0, "t6_after_rst_fall");

    repeat (5) @(negedge clk);
    chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
